// File: rtl/param_pattern_seq.sv
// Banked constant-pattern sequencer: streams the rows of one selected TABLE bank
// as COLS-bit words over valid/ready, with one-shot or loop mode, stop and a pass counter.
module param_pattern_seq #(
  parameter int BANKS = 2,
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter logic TABLE [BANKS-1:0][ROWS-1:0][COLS-1:0] = '{
    '{ '{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1} },
    '{ '{1'b0, 1'b1, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1} }
  }
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BW-1:0]   i_bank_sel,
  input  logic            i_loop,
  input  logic            i_stop,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [COLS-1:0] o_out_data,
  output logic [RW-1:0]   o_out_row,
  output logic            o_out_last,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [7:0]      o_pass_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t          r_state, w_nextState;
  logic [BW-1:0]   r_bank, w_bank;
  logic            r_loop, w_loop;
  logic [RW-1:0]   r_row, w_row;
  logic [COLS-1:0] r_data, w_data;
  logic            r_valid, w_valid;
  logic            r_last, w_last;
  logic            r_done, w_done;
  logic            r_err, w_err;
  logic [7:0]      r_passCnt, w_passCnt;

  logic            w_bankOk;
  logic            w_beat;
  logic            w_atLast;
  logic [RW-1:0]   w_rowInc;

  // Table bits are stored per column, so a row word is gathered bit by bit.
  function automatic logic [COLS-1:0] rowWord(input logic [BW-1:0] b, input logic [RW-1:0] r);
    logic [COLS-1:0] word;
    for (int c = 0; c < COLS; c++) word[c] = TABLE[b][r][c];
    return word;
  endfunction

  assign w_bankOk = (32'(i_bank_sel) < 32'(BANKS));
  assign w_beat   = r_valid & i_out_ready;
  assign w_atLast = (r_row == LAST_ROW);
  assign w_rowInc = r_row + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (i_start && w_bankOk) w_nextState = RUN;
      RUN:  if (i_stop || (w_beat && w_atLast && !r_loop)) w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_bank    = r_bank;
    w_loop    = r_loop;
    w_row     = r_row;
    w_data    = r_data;
    w_valid   = r_valid;
    w_last    = r_last;
    w_passCnt = r_passCnt;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (!w_bankOk) begin
            w_err = 1'b1;
          end else begin
            w_bank    = i_bank_sel;
            w_loop    = i_loop;
            w_row     = '0;
            w_passCnt = '0;
            w_valid   = 1'b1;
            w_data    = rowWord(i_bank_sel, '0);
            w_last    = (LAST_ROW == '0);
          end
        end
      end
      RUN: begin
        if (w_beat) begin
          if (!w_atLast) begin
            w_row  = w_rowInc;
            w_data = rowWord(r_bank, w_rowInc);
            w_last = (w_rowInc == LAST_ROW);
          end else begin
            w_passCnt = r_passCnt + 8'd1;
            if (r_loop) begin
              w_row  = '0;
              w_data = rowWord(r_bank, '0);
              w_last = (LAST_ROW == '0);
            end else begin
              w_valid = 1'b0;
              w_done  = !i_stop;
            end
          end
        end
        // A stop still lets a same-cycle handshake count, but never reports done.
        if (i_stop) w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bank    <= '0;
      r_loop    <= 1'b0;
      r_row     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_passCnt <= '0;
    end else begin
      r_bank    <= w_bank;
      r_loop    <= w_loop;
      r_row     <= w_row;
      r_data    <= w_data;
      r_valid   <= w_valid;
      r_last    <= w_last;
      r_done    <= w_done;
      r_err     <= w_err;
      r_passCnt <= w_passCnt;
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
  assign o_out_row   = r_row;
  assign o_out_last  = r_last;
  assign o_busy      = (r_state == RUN);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_pass_cnt  = r_passCnt;

endmodule

// File: doc/param_pattern_seq.md
# param_pattern_seq

Parametrised pattern sequencer that stores a three-dimensional unpacked constant table `TABLE[BANK][ROW][COL]` and streams the rows of one selected bank as COLS-bit words over a valid/ready interface. It generalises a fixed constant lookup into a run-time sequenced source with bank select, one-shot or loop mode, early stop and a pass counter. It sits between configuration logic, which issues `start`, and any downstream consumer of fixed bit patterns, such as test-vector or init-sequence drivers.

## Interface
- BANKS, 2, number of banks (≥1)
- ROWS, 3, rows per bank (≥1)
- COLS, 4, bits per row; output word width (≥1)
- TABLE, see below, `parameter logic TABLE [BANKS-1:0][ROWS-1:0][COLS-1:0]`. Default: every row = 4'b0111 (bit c at index c), except TABLE[1][2] = 4'b0101.
- Derived: BW = (BANKS>1) ? $clog2(BANKS) : 1; RW = (ROWS>1) ? $clog2(ROWS) : 1
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a sequence
- bank_sel  in  BW  bank to play; sampled only when `start` is accepted
- loop  in  1  sampled with `start`: 1 = wrap to row 0 forever; 0 = one pass
- stop  in  1  abort the current sequence
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the beat
- out_data  out  COLS  out_data[c] = TABLE[bank][row][c]
- out_row  out  RW  row index of the current beat
- out_last  out  1  current beat is row ROWS-1
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when a one-shot pass completes
- err  out  1  one-cycle pulse when `start` carries bank_sel ≥ BANKS
- pass_cnt  out  8  completed passes since the last accepted start, modulo 256

## Operation
- States: IDLE, RUN.
- IDLE with start=1:
  - If bank_sel ≥ BANKS: pulse err, remain IDLE, leave all other registers unchanged.
  - Otherwise: latch bank and loop, set row=0, clear pass_cnt, go to RUN, and load out_data=TABLE[bank][0], out_row=0, out_last=(ROWS==1), out_valid=1.
- RUN, beat accepted (out_valid & out_ready):
  - If row < ROWS-1: row+1; reload out_data, out_row and out_last.
  - If row == ROWS-1: pass_cnt+1 (wraps 255→0).
    - loop=1: row=0, stay in RUN, out_valid stays 1.
    - loop=0: go to IDLE, out_valid=0, pulse done.
- RUN, no handshake: out_data, out_row and out_last hold stable; out_valid stays 1.
- stop=1 in RUN:
  - Next state is IDLE and out_valid=0. done does not pulse.
  - A handshake in the same cycle still counts, including its pass_cnt increment.
- start while in RUN is ignored; err does not fire. stop in IDLE has no effect.
- start and stop together in IDLE: start is honoured.
- busy = (state == RUN).
- Parameter changes must need no RTL edits; ROWS=1 and BANKS=1 are legal.

## Timing
- Reset (synchronous): state IDLE; out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, done=0, err=0, pass_cnt=0. rst overrides start, stop and handshakes in the same cycle.
- Latency: start accepted at edge N → out_valid=1 with row 0 after edge N. The first handshake can happen in the following cycle.
- Throughput: one beat per cycle while out_ready=1. No bubble at loop wrap.
- One-shot with out_ready held high: ROWS beats, then done=1 in the cycle after the last handshake edge. A new start is accepted in that same cycle.
- err, done: registered, high for exactly one cycle.
- All outputs are registered. out_data must not change while out_valid=1 and out_ready=0.

## Test plan
- Reset, then idle: all outputs 0 and no activity for 10 cycles.
- start, bank_sel=1, loop=0, out_ready=1 → out_data 0111, 0111, 0101 on rows 0,1,2; out_last only on row 2; done one cycle later; pass_cnt=1; busy=0.
- bank 0, loop=0, out_ready toggling 1,0,0,1,… → data holds during stalls; three beats of 0111; done once.
- bank 1, loop=1, out_ready=1 for 9 beats, then stop → beats repeat 0111, 0111, 0101 with no gap; pass_cnt=3; no done; out_valid=0 the cycle after stop.
- start with bank_sel=3 (BW=1 wraps to 1, so use BANKS=3, bank_sel=3) → err pulse; state stays IDLE; out_valid=0.
- rst asserted mid-RUN at row 1 → next cycle all outputs at reset values; a subsequent start restarts at row 0 with pass_cnt=0.
